// File: rtl/smvm_issue_ctrl.sv
// SMVM front-end: parses header/vector/triplet byte stream, writes the vector RAM and
// issues K-lane triplet bundles downstream over a valid/ready handshake.
module smvm_issue_ctrl #(
  parameter int unsigned K        = 4,
  parameter int unsigned MAX_COLS = 128,
  localparam int unsigned AW      = $clog2(MAX_COLS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     data_in_i,
  input  logic           in_valid_i,
  input  logic           in_last_i,
  output logic           in_ready_o,
  output logic           vec_we_o,
  output logic [AW-1:0]  vec_addr_o,
  output logic [7:0]     vec_wdata_o,
  output logic           issue_valid_o,
  input  logic           issue_ready_i,
  output logic [8*K-1:0] issue_val_o,
  output logic [8*K-1:0] issue_col_o,
  output logic [K-1:0]   issue_ipv_o,
  output logic [K-1:0]   issue_mask_o,
  output logic [7:0]     rows_out_o,
  output logic [7:0]     cols_out_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_col_o,
  output logic           err_rows_o,
  output logic           err_fmt_o
);

  localparam int unsigned LW = $clog2(K);

  typedef enum logic [2:0] {StIdle, StCols, StVec, StVal, StIdx, StIpv, StDrain} state_e;

  state_e           state_q, state_d;
  logic [7:0]       rows_q, rows_d, cols_q, cols_d, vec_cnt_q, vec_cnt_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [7:0]       g_val_q [K];
  logic [7:0]       g_val_d [K];
  logic [7:0]       g_col_q [K];
  logic [7:0]       g_col_d [K];
  logic [K-1:0]     g_ipv_q, g_ipv_d;
  logic [8*K-1:0]   iss_val_q, iss_val_d, iss_col_q, iss_col_d;
  logic [K-1:0]     iss_ipv_q, iss_ipv_d, iss_mask_q, iss_mask_d;
  logic             iss_valid_q, iss_valid_d;
  logic [8:0]       row_cnt_q, row_cnt_d;
  logic [9:0]       row_sum;
  logic             err_col_q, err_col_d, err_rows_q, err_rows_d, err_fmt_q, err_fmt_d;
  logic             done_q, done_d;
  logic             rdy_en_q;
  logic             accept, iss_fire, trig;

  assign trig     = (state_q == StIpv) && ((lane_q == LW'(K - 1)) || in_last_i);
  assign iss_fire = iss_valid_q && issue_ready_i;
  // Hold off an issuing ipv byte only while the issue register cannot drain this cycle.
  assign in_ready_o = rdy_en_q && (state_q != StDrain) &&
                      !(trig && iss_valid_q && !issue_ready_i);
  assign accept   = in_valid_i && in_ready_o;

  assign vec_we_o      = accept && (state_q == StVec) && (32'(vec_cnt_q) < MAX_COLS);
  assign vec_addr_o    = vec_cnt_q[AW-1:0];
  assign vec_wdata_o   = data_in_i;
  assign issue_valid_o = iss_valid_q;
  assign issue_val_o   = iss_val_q;
  assign issue_col_o   = iss_col_q;
  assign issue_ipv_o   = iss_ipv_q;
  assign issue_mask_o  = iss_mask_q;
  assign rows_out_o    = rows_q;
  assign cols_out_o    = cols_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign err_col_o     = err_col_q;
  assign err_rows_o    = err_rows_q;
  assign err_fmt_o     = err_fmt_q;

  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    vec_cnt_d   = vec_cnt_q;
    lane_d      = lane_q;
    g_val_d     = g_val_q;
    g_col_d     = g_col_q;
    g_ipv_d     = g_ipv_q;
    iss_val_d   = iss_val_q;
    iss_col_d   = iss_col_q;
    iss_ipv_d   = iss_ipv_q;
    iss_mask_d  = iss_mask_q;
    iss_valid_d = iss_valid_q;
    row_cnt_d   = row_cnt_q;
    err_col_d   = err_col_q;
    err_rows_d  = err_rows_q;
    err_fmt_d   = err_fmt_q;
    done_d      = 1'b0;

    row_sum = {1'b0, row_cnt_q};
    for (int i = 0; i < K; i++) begin
      row_sum = row_sum + 10'(iss_ipv_q[i] & iss_mask_q[i]);
    end

    if (iss_fire) begin
      iss_valid_d = 1'b0;
      row_cnt_d   = row_sum[9] ? 9'h1FF : row_sum[8:0];
      if (state_q == StDrain) begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (row_cnt_d != {1'b0, rows_q}) err_rows_d = 1'b1;
      end
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          rows_d     = data_in_i;
          row_cnt_d  = '0;
          err_col_d  = 1'b0;
          err_rows_d = 1'b0;
          err_fmt_d  = 1'b0;
          state_d    = StCols;
        end
        StCols: begin
          cols_d    = data_in_i;
          vec_cnt_d = '0;
          lane_d    = '0;
          if (32'(data_in_i) > MAX_COLS) err_fmt_d = 1'b1;
          state_d = (data_in_i == 8'd0) ? StVal : StVec;
        end
        StVec: begin
          if (vec_cnt_q == cols_q - 8'd1) begin
            vec_cnt_d = '0;
            state_d   = StVal;
          end else begin
            vec_cnt_d = vec_cnt_q + 8'd1;
          end
        end
        StVal: begin
          g_val_d[lane_q] = data_in_i;
          state_d         = StIdx;
        end
        StIdx: begin
          g_col_d[lane_q] = data_in_i;
          if (data_in_i >= cols_q) begin
            err_col_d       = 1'b1;
            g_val_d[lane_q] = 8'd0;
          end
          state_d = StIpv;
        end
        StIpv: begin
          g_ipv_d[lane_q] = data_in_i[0];
          if (trig) begin
            for (int i = 0; i < K; i++) begin
              if (LW'(i) <= lane_q) begin
                iss_val_d[8*i +: 8] = g_val_q[i];
                iss_col_d[8*i +: 8] = g_col_q[i];
                iss_ipv_d[i]        = (LW'(i) == lane_q) ? data_in_i[0] : g_ipv_q[i];
                iss_mask_d[i]       = 1'b1;
              end else begin
                iss_val_d[8*i +: 8] = 8'd0;
                iss_col_d[8*i +: 8] = 8'd0;
                iss_ipv_d[i]        = 1'b0;
                iss_mask_d[i]       = 1'b0;
              end
            end
            iss_valid_d = 1'b1;
            lane_d      = '0;
            state_d     = in_last_i ? StDrain : StVal;
          end else begin
            lane_d  = lane_q + LW'(1);
            state_d = StVal;
          end
        end
        default: ;
      endcase
      // A stray frame marker is flagged but does not alter parsing.
      if (in_last_i && (state_q != StIpv)) err_fmt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rows_q      <= '0;
      cols_q      <= '0;
      vec_cnt_q   <= '0;
      lane_q      <= '0;
      for (int i = 0; i < K; i++) begin
        g_val_q[i] <= '0;
        g_col_q[i] <= '0;
      end
      g_ipv_q     <= '0;
      iss_val_q   <= '0;
      iss_col_q   <= '0;
      iss_ipv_q   <= '0;
      iss_mask_q  <= '0;
      iss_valid_q <= 1'b0;
      row_cnt_q   <= '0;
      err_col_q   <= 1'b0;
      err_rows_q  <= 1'b0;
      err_fmt_q   <= 1'b0;
      done_q      <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      vec_cnt_q   <= vec_cnt_d;
      lane_q      <= lane_d;
      g_val_q     <= g_val_d;
      g_col_q     <= g_col_d;
      g_ipv_q     <= g_ipv_d;
      iss_val_q   <= iss_val_d;
      iss_col_q   <= iss_col_d;
      iss_ipv_q   <= iss_ipv_d;
      iss_mask_q  <= iss_mask_d;
      iss_valid_q <= iss_valid_d;
      row_cnt_q   <= row_cnt_d;
      err_col_q   <= err_col_d;
      err_rows_q  <= err_rows_d;
      err_fmt_q   <= err_fmt_d;
      done_q      <= done_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_smvm_issue_ctrl.sv
// Bench for smvm_issue_ctrl: table of frames/triplets, scoreboards for vector writes and bundles,
// plus hand-written reset and stall sequences.
module tb_smvm_issue_ctrl;

  localparam int unsigned K        = 4;
  localparam int unsigned MAX_COLS = 128;
  localparam int unsigned AW       = $clog2(MAX_COLS);

  typedef struct {
    logic [7:0] val;
    logic [7:0] col;
    logic       ipv;
    logic       last;
    logic       lval;
    logic [7:0] exp_val;
  } trip_t;

  typedef struct {
    logic [7:0] rows;
    logic [7:0] cols;
    int         first;
    int         n;
    bit         stall;
    logic       ec;
    logic       er;
    logic       ef;
  } frame_t;

  typedef struct {
    logic [8*K-1:0] val;
    logic [8*K-1:0] col;
    logic [K-1:0]   ipv;
    logic [K-1:0]   mask;
  } bundle_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     data_in = '0;
  logic           in_valid = 1'b0, in_last = 1'b0, issue_ready = 1'b1;
  logic           in_ready, vec_we, issue_valid, busy, done, err_col, err_rows, err_fmt;
  logic [AW-1:0]  vec_addr;
  logic [7:0]     vec_wdata, rows_out, cols_out;
  logic [8*K-1:0] issue_val, issue_col;
  logic [K-1:0]   issue_ipv, issue_mask;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int vcount = 0;
  trip_t   trips[$];
  frame_t  frames[$];
  bundle_t bq[$];
  logic [AW+7:0] vq[$];

  smvm_issue_ctrl #(.K(K), .MAX_COLS(MAX_COLS)) dut (
    .clk(clk), .rst_n(rst_n), .data_in_i(data_in), .in_valid_i(in_valid), .in_last_i(in_last),
    .in_ready_o(in_ready), .vec_we_o(vec_we), .vec_addr_o(vec_addr), .vec_wdata_o(vec_wdata),
    .issue_valid_o(issue_valid), .issue_ready_i(issue_ready), .issue_val_o(issue_val),
    .issue_col_o(issue_col), .issue_ipv_o(issue_ipv), .issue_mask_o(issue_mask),
    .rows_out_o(rows_out), .cols_out_o(cols_out), .busy_o(busy), .done_o(done),
    .err_col_o(err_col), .err_rows_o(err_rows), .err_fmt_o(err_fmt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_trip(input logic [7:0] v, input logic [7:0] c, input logic ipv,
                          input logic last, input logic lval, input logic [7:0] ev);
    trip_t t;
    t.val = v; t.col = c; t.ipv = ipv; t.last = last; t.lval = lval; t.exp_val = ev;
    trips.push_back(t);
  endtask

  task automatic add_frame(input logic [7:0] r, input logic [7:0] c, input int first, input int n,
                           input bit stall, input logic ec, input logic er, input logic ef);
    frame_t f;
    f.rows = r; f.cols = c; f.first = first; f.n = n; f.stall = stall;
    f.ec = ec; f.er = er; f.ef = ef;
    frames.push_back(f);
  endtask

  // Called aligned at posedge+1; returns aligned at posedge+1 after the byte is accepted.
  task automatic send(input logic [7:0] b, input logic last);
    bit ok = 0;
    data_in = b; in_last = last; in_valid = 1'b1;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic send_trips(input frame_t f);
    logic [7:0]   mv [K];
    logic [7:0]   mc [K];
    logic [K-1:0] mi = '0;
    int           l = 0;
    bundle_t      b;
    for (int t = f.first; t < f.first + f.n; t++) begin
      mv[l] = trips[t].exp_val;
      mc[l] = trips[t].col;
      mi[l] = trips[t].ipv;
      if (l == K - 1 || trips[t].last) begin
        for (int j = 0; j < K; j++) begin
          b.val[8*j +: 8] = (j <= l) ? mv[j] : 8'd0;
          b.col[8*j +: 8] = (j <= l) ? mc[j] : 8'd0;
          b.ipv[j]        = (j <= l) ? mi[j] : 1'b0;
          b.mask[j]       = (j <= l);
        end
        bq.push_back(b);
        l = 0;
      end else begin
        l++;
      end
      send(trips[t].val, trips[t].lval);
      send(trips[t].col, 1'b0);
      send({7'd0, trips[t].ipv}, trips[t].last);
    end
  endtask

  task automatic run_frame(input int fi);
    frame_t f = frames[fi];
    int     expw;
    bit     seen = 0;
    done_cnt = 0;
    vcount   = 0;
    send(f.rows, 1'b0);
    send(f.cols, 1'b0);
    for (int i = 0; i < f.cols; i++) begin
      if (i < MAX_COLS) vq.push_back({AW'(i), 8'(i + 1)});
      send(8'(i + 1), 1'b0);
    end
    if (f.stall) begin
      issue_ready = 1'b0;
      fork
        send_trips(f);
        begin
          for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (in_valid && !in_ready) seen = 1;
          end
          repeat (10) @(negedge clk);
          @(posedge clk); #1;
          issue_ready = 1'b1;
        end
      join
      chk("stall_in_ready_drop", {63'd0, seen}, 64'd1);
    end else begin
      send_trips(f);
    end
    for (int c = 0; c < 200 && done_cnt == 0; c++) @(negedge clk);
    chk($sformatf("f%0d_done_seen", fi), {63'd0, done_cnt > 0}, 64'd1);
    repeat (3) @(negedge clk);
    expw = (f.cols > MAX_COLS) ? MAX_COLS : f.cols;
    chk($sformatf("f%0d_done_pulses", fi), 64'(done_cnt), 64'd1);
    chk($sformatf("f%0d_vec_writes", fi), 64'(vcount), 64'(expw));
    chk($sformatf("f%0d_bundles_left", fi), 64'(bq.size()), 64'd0);
    chk($sformatf("f%0d_errs", fi), {61'd0, err_col, err_rows, err_fmt}, {61'd0, f.ec, f.er, f.ef});
    chk($sformatf("f%0d_rows_cols", fi), {48'd0, rows_out, cols_out}, {48'd0, f.rows, f.cols});
    chk($sformatf("f%0d_busy", fi), {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && vec_we) begin
      vcount++;
      if (vq.size() == 0) chk("vec_unexpected_write", 64'd1, 64'd0);
      else chk("vec_write", {48'd0, vec_addr, vec_wdata}, {48'd0, vq.pop_front()});
    end
  end

  always @(negedge clk) begin
    bundle_t e;
    if (rst_n && issue_valid && issue_ready) begin
      if (bq.size() == 0) begin
        chk("bundle_unexpected", 64'd1, 64'd0);
      end else begin
        e = bq.pop_front();
        chk("bundle_mask", 64'(issue_mask), 64'(e.mask));
        chk("bundle_ipv", 64'(issue_ipv), 64'(e.ipv));
        chk("bundle_val", 64'(issue_val), 64'(e.val));
        chk("bundle_col", 64'(issue_col), 64'(e.col));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      chk("done_after_last_bundle", 64'(bq.size()), 64'd0);
    end
  end

  initial begin
    // F0: rows=2 cols=3, ipv on #2/#4
    add_trip(8'd10, 8'd0, 1'b0, 1'b0, 1'b0, 8'd10);
    add_trip(8'hFB, 8'd1, 1'b1, 1'b0, 1'b0, 8'hFB);
    add_trip(8'd7,  8'd2, 1'b0, 1'b0, 1'b0, 8'd7);
    add_trip(8'd3,  8'd0, 1'b1, 1'b1, 1'b0, 8'd3);
    // F1: 6 triplets -> full bundle then 2-lane partial
    for (int i = 0; i < 6; i++)
      add_trip(8'(i + 1), 8'(i % 4), i == 5, i == 5, 1'b0, 8'(i + 1));
    // F2: 8 triplets, used with downstream stall
    for (int i = 0; i < 8; i++)
      add_trip(8'(20 + i), 8'(i % 2), (i == 3) || (i == 7), i == 7, 1'b0, 8'(20 + i));
    // F3: out-of-range col and missing row flag
    add_trip(8'd9,  8'd0, 1'b0, 1'b0, 1'b0, 8'd9);
    add_trip(8'd11, 8'd5, 1'b1, 1'b0, 1'b0, 8'd0);
    add_trip(8'd12, 8'd1, 1'b0, 1'b0, 1'b0, 8'd12);
    add_trip(8'd13, 8'd2, 1'b1, 1'b1, 1'b0, 8'd13);
    // F4: in_last on a val byte
    add_trip(8'd40, 8'd0, 1'b0, 1'b0, 1'b1, 8'd40);
    add_trip(8'd41, 8'd0, 1'b1, 1'b1, 1'b0, 8'd41);
    // F5: cols=200 overflow
    add_trip(8'd50, 8'd150, 1'b1, 1'b1, 1'b0, 8'd50);

    add_frame(8'd2, 8'd3,   0,  4, 0, 1'b0, 1'b0, 1'b0);
    add_frame(8'd1, 8'd4,   4,  6, 0, 1'b0, 1'b0, 1'b0);
    add_frame(8'd2, 8'd2,   10, 8, 1, 1'b0, 1'b0, 1'b0);
    add_frame(8'd3, 8'd3,   18, 4, 0, 1'b1, 1'b1, 1'b0);
    add_frame(8'd1, 8'd1,   22, 2, 0, 1'b0, 1'b0, 1'b1);
    add_frame(8'd1, 8'd200, 24, 1, 0, 1'b0, 1'b0, 1'b1);

    #12;
    chk("reset_ctrl", {50'd0, in_ready, vec_we, issue_valid, issue_mask, issue_ipv, busy, done,
                        err_col, err_rows, err_fmt}, 64'd0);
    chk("reset_data", {issue_val, issue_col}, 64'd0);
    chk("reset_hdr", {48'd0, rows_out, cols_out}, 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int fi = 0; fi < 5; fi++) run_frame(fi);

    // Asynchronous reset while the controller waits for a col byte
    send(8'd2, 1'b0);
    send(8'd2, 1'b0);
    vq.push_back({AW'(0), 8'd5});
    send(8'd5, 1'b0);
    vq.push_back({AW'(1), 8'd6});
    send(8'd6, 1'b0);
    send(8'd7, 1'b0);
    chk("midframe_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {50'd0, in_ready, vec_we, issue_valid, issue_mask, issue_ipv, busy,
                              done, err_col, err_rows, err_fmt}, 64'd0);
    chk("async_reset_data", {issue_val, issue_col}, 64'd0);
    chk("async_reset_hdr", {48'd0, rows_out, cols_out}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_frame(0);
    run_frame(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
